// File: rtl/if_fetch_pkg.sv
// Shared CPU fetch constants: reset/legal-range addresses, NOP encoding and fetch FSM states.
package if_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT_DEF = 32'h0000_6FFC;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_if_id_reg.sv
// Pipeline register (PC, instruction, exception flag) with load enable and a
// load-nop override that replaces the instruction word with NOP.
module if_fetch_if_id_reg
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic        nop_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        exc_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        exc_o
);

    logic [31:0] pc_q, instr_q;
    logic        exc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            instr_q <= NOP;
            exc_q   <= 1'b0;
        end else if (en_i) begin
            pc_q    <= pc_i;
            instr_q <= nop_i ? NOP : instr_i;
            exc_q   <= exc_i;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign exc_o   = exc_q;

endmodule

// File: rtl/if_fetch.sv
// Fetch stage: owns the PC, issues req/ack instruction reads, and loads IF/ID,
// absorbing memory latency and decode stalls through a one-entry skid buffer.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter logic [31:0] IM_LIMIT = IM_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_Next,
    input  logic        Stall,
    output logic        IM_Req,
    output logic [31:0] IM_Addr,
    input  logic        IM_Ack,
    input  logic [31:0] IM_Rdata,
    output logic [31:0] PC_Out,
    output logic [31:0] PC_D,
    output logic [31:0] Instr_D,
    output logic        Exc_AdEL_D,
    output logic        Fetch_Busy
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  skid_q, skid_d;
    logic         legal;
    logic         ack_v;
    logic         advance;
    logic         load_nop;
    logic [31:0]  load_word;

    assign legal = (pc_q[1:0] == 2'b00) && (pc_q >= IM_BASE) && (pc_q <= IM_LIMIT);

    // An ack only counts while a request is actually on the bus.
    assign IM_Req     = !reset && (state_q == S_REQ) && legal;
    assign ack_v      = IM_Req && IM_Ack;
    assign Fetch_Busy = IM_Req && !IM_Ack;
    assign IM_Addr    = pc_q;
    assign PC_Out     = pc_q;

    always_comb begin
        state_d   = state_q;
        skid_d    = skid_q;
        advance   = 1'b0;
        load_nop  = 1'b0;
        load_word = IM_Rdata;
        unique case (state_q)
            S_REQ: begin
                if (!legal) begin
                    // Illegal fetch resolves locally in one cycle as a faulting nop.
                    if (!Stall) begin
                        advance  = 1'b1;
                        load_nop = 1'b1;
                    end
                end else if (ack_v) begin
                    if (!Stall) begin
                        advance = 1'b1;
                    end else begin
                        skid_d  = IM_Rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!Stall) begin
                    advance   = 1'b1;
                    load_word = skid_q;
                    state_d   = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
        pc_d = advance ? PC_Next : pc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            skid_q  <= NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
        end
    end

    if_fetch_if_id_reg u_if_id (
        .clk     (clk),
        .reset   (reset),
        .en_i    (advance),
        .nop_i   (load_nop),
        .pc_i    (pc_q),
        .instr_i (load_word),
        .exc_i   (load_nop),
        .pc_o    (PC_D),
        .instr_o (Instr_D),
        .exc_o   (Exc_AdEL_D)
    );

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Fetch-stage owner of the program counter; the consumer of the next-PC value computed by the NPC logic.
- Holds the PC register and drives PC_Out back to the NPC block.
- Issues instruction-memory reads over a req/ack handshake and loads the IF/ID pipeline register (PC_D, Instr_D) that feeds decode.
- Absorbs variable memory latency and decode stalls without losing an instruction or a branch target.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; all state is set on the clk edge while asserted.
- PC_Next  in  32  next fetch address from NPC, already selected between PC+4, branch, jump and register targets.
- Stall  in  1  decode-stage stall from hazard unit; IF/ID and PC must hold.
- IM_Req  out  1  instruction-memory read request.
- IM_Addr  out  32  read address, always equal to PC_Out.
- IM_Ack  in  1  read data valid this cycle; sampled only while IM_Req=1.
- IM_Rdata  in  32  instruction word, valid with IM_Ack.
- PC_Out  out  32  current F-stage PC, fed to NPC.
- PC_D  out  32  PC of the instruction in D.
- Instr_D  out  32  instruction in D.
- Exc_AdEL_D  out  1  D instruction carries an address-error-on-fetch.
- Fetch_Busy  out  1  a fetch is outstanding; the hazard unit ORs this into the D-stage freeze.

Behaviour:
- Reset values: PC=RESET_PC, PC_D=0, Instr_D=0, Exc_AdEL_D=0, state=S_REQ. IM_Req is forced 0 during the reset cycle. An IM_Ack in the reset cycle is ignored.
- Advance event: the D stage accepts a new instruction. On advance, IF/ID loads the fetched word and PC<=PC_Next in the same edge.
  - PC_Next is computed from the instruction currently in D. That instruction stays frozen until advance, so delay-slot semantics hold: branch in D, delay slot in F, target loaded at advance.
- Illegal address: PC[1:0]!=0, PC<IM_BASE or PC>IM_LIMIT. The block issues no memory request. The next advance loads Instr_D=0 (nop) with Exc_AdEL_D=1 and PC_D=PC; this takes 1 cycle, same as a legal hit.
- States:
  - S_REQ: IM_Req=1 for a legal PC, Fetch_Busy=1 until IM_Ack.
    - IM_Ack & !Stall: advance; stay in S_REQ for the next PC (back-to-back fetch, 1 instr/cycle on zero-wait memory).
    - IM_Ack & Stall: capture IM_Rdata into a skid buffer, go to S_HOLD.
    - !IM_Ack: no change. IF/ID holds because Fetch_Busy freezes D.
  - S_HOLD: IM_Req=0, Fetch_Busy=0.
    - !Stall: advance from the skid buffer, go to S_REQ.
    - Stall: hold.
- Stall with no outstanding data (S_REQ, no ack): keep the request asserted, addr unchanged.
- IM_Addr must stay stable while IM_Req=1 and !IM_Ack. PC never changes mid-request.
- Reset mid-request: the outstanding request is abandoned. The memory must drop it, and the first post-reset request is to RESET_PC.
- PC_Next is registered verbatim; there is no internal +4. The PC+4 path lives in NPC.
- Exc_AdEL_D is cleared when a legal instruction advances.
- Size target: roughly 150–250 lines of RTL.

Decomposition:
- Shared CPU package:
  - RESET_PC, IM_BASE and IM_LIMIT constants.
  - NOP encoding (32'h0).
  - Fetch FSM state enum {S_REQ, S_HOLD}.
- Optional sub-module if_id_reg: IF/ID register with enable and a load-nop input, reusable for other pipeline registers.
- Address-legality check stays inline.

Test Plan:
- Zero-wait memory, IM_Ack same cycle as IM_Req, PC_Next=PC_Out+4 → one instruction per cycle. PC_D sequence 0x3000, 0x3004, 0x3008, Instr_D matches the memory image.
- Memory with 3-cycle latency at 0x3004 → IM_Addr held at 0x3004 for 3 cycles, Fetch_Busy=1, Instr_D/PC_D unchanged, then advance to PC_D=0x3004.
- IM_Ack arrives while Stall=1 for 2 cycles → IM_Req drops, state S_HOLD. After the stall releases, Instr_D equals the buffered word. No duplicate or dropped fetch.
- beq in D at 0x3008 with PC_Next=0x3020 during delay-slot fetch → PC_D goes 0x300C then 0x3020.
- PC_Next=0x3002 → no IM_Req. Next D has Instr_D=0, Exc_AdEL_D=1, PC_D=0x3002.
- Reset asserted mid-request at 0x3010 → IM_Req=0 in the reset cycle, next request to 0x3000, PC_D=0, Instr_D=0.
